// File: rtl/mips_isa_pkg.sv
// Shared MIPS-I encoding constants, the loader mnemonic enumeration and encoder FSM states.
// The opcode/funct values match what the main control decoder and ALU control expect.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef enum logic [5:0] {
        MN_NOP   = 6'd0,
        MN_ADD   = 6'd1,
        MN_ADDU  = 6'd2,
        MN_SUB   = 6'd3,
        MN_SUBU  = 6'd4,
        MN_AND   = 6'd5,
        MN_OR    = 6'd6,
        MN_XOR   = 6'd7,
        MN_NOR   = 6'd8,
        MN_SLT   = 6'd9,
        MN_SLTU  = 6'd10,
        MN_SLL   = 6'd11,
        MN_SRL   = 6'd12,
        MN_SRA   = 6'd13,
        MN_SLLV  = 6'd14,
        MN_SRLV  = 6'd15,
        MN_SRAV  = 6'd16,
        MN_JR    = 6'd17,
        MN_LW    = 6'd18,
        MN_SW    = 6'd19,
        MN_BEQ   = 6'd20,
        MN_BNE   = 6'd21,
        MN_ADDI  = 6'd22,
        MN_ADDIU = 6'd23,
        MN_ANDI  = 6'd24,
        MN_ORI   = 6'd25,
        MN_XORI  = 6'd26,
        MN_SLTI  = 6'd27,
        MN_SLTIU = 6'd28,
        MN_LUI   = 6'd29,
        MN_J     = 6'd30,
        MN_JAL   = 6'd31
    } mnem_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } encState_e;

    function automatic logic isShiftImm(input logic [5:0] mnem);
        return (mnem == MN_SLL) || (mnem == MN_SRL) || (mnem == MN_SRA);
    endfunction

endpackage

// File: rtl/mips_inst_enc_core.sv
// Combinational instruction encoder: mnemonic plus fields -> 32-bit MIPS word.
// Unused fields are always zeroed in the word; fieldViol reports that one was nonzero.
module mips_inst_enc_core
    import mips_isa_pkg::*;
(
    input  logic [5:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal,
    output logic        fieldViol
);

    logic [5:0] funct;
    logic [5:0] opcode;
    logic       isR;
    logic       isJ;
    logic [4:0] rsEff;
    logic [4:0] rtEff;
    logic [4:0] rdEff;
    logic [4:0] shEff;

    always_comb begin
        funct  = 6'b000000;
        opcode = OP_RTYPE;
        isR    = 1'b0;
        isJ    = 1'b0;
        case (mnem)
            MN_ADD:   begin isR = 1'b1; funct = FN_ADD;  end
            MN_ADDU:  begin isR = 1'b1; funct = FN_ADDU; end
            MN_SUB:   begin isR = 1'b1; funct = FN_SUB;  end
            MN_SUBU:  begin isR = 1'b1; funct = FN_SUBU; end
            MN_AND:   begin isR = 1'b1; funct = FN_AND;  end
            MN_OR:    begin isR = 1'b1; funct = FN_OR;   end
            MN_XOR:   begin isR = 1'b1; funct = FN_XOR;  end
            MN_NOR:   begin isR = 1'b1; funct = FN_NOR;  end
            MN_SLT:   begin isR = 1'b1; funct = FN_SLT;  end
            MN_SLTU:  begin isR = 1'b1; funct = FN_SLTU; end
            MN_SLL:   begin isR = 1'b1; funct = FN_SLL;  end
            MN_SRL:   begin isR = 1'b1; funct = FN_SRL;  end
            MN_SRA:   begin isR = 1'b1; funct = FN_SRA;  end
            MN_SLLV:  begin isR = 1'b1; funct = FN_SLLV; end
            MN_SRLV:  begin isR = 1'b1; funct = FN_SRLV; end
            MN_SRAV:  begin isR = 1'b1; funct = FN_SRAV; end
            MN_JR:    begin isR = 1'b1; funct = FN_JR;   end
            MN_LW:    opcode = OP_LW;
            MN_SW:    opcode = OP_SW;
            MN_BEQ:   opcode = OP_BEQ;
            MN_BNE:   opcode = OP_BNE;
            MN_ADDI:  opcode = OP_ADDI;
            MN_ADDIU: opcode = OP_ADDIU;
            MN_ANDI:  opcode = OP_ANDI;
            MN_ORI:   opcode = OP_ORI;
            MN_XORI:  opcode = OP_XORI;
            MN_SLTI:  opcode = OP_SLTI;
            MN_SLTIU: opcode = OP_SLTIU;
            MN_LUI:   opcode = OP_LUI;
            MN_J:     begin isJ = 1'b1; opcode = OP_J;   end
            MN_JAL:   begin isJ = 1'b1; opcode = OP_JAL; end
            default:  opcode = OP_RTYPE;
        endcase
    end

    // Field sanitising: shift-immediate and LUI ignore rs, JR uses rs only,
    // every other R-type has no shift amount.
    always_comb begin
        rsEff     = rs;
        rtEff     = rt;
        rdEff     = rd;
        shEff     = shamt;
        fieldViol = 1'b0;
        if (isShiftImm(mnem) || (mnem == MN_LUI)) begin
            rsEff     = 5'd0;
            fieldViol = (rs != 5'd0);
        end else if (mnem == MN_JR) begin
            rtEff     = 5'd0;
            rdEff     = 5'd0;
            shEff     = 5'd0;
            fieldViol = (rt != 5'd0) || (rd != 5'd0) || (shamt != 5'd0);
        end else if (isR) begin
            shEff     = 5'd0;
            fieldViol = (shamt != 5'd0);
        end
    end

    always_comb begin
        illegal = mnem[5];
        word    = 32'h0000_0000;
        if (mnem[5] || (mnem == MN_NOP)) begin
            word = 32'h0000_0000;
        end else if (isR) begin
            word = {OP_RTYPE, rsEff, rtEff, rdEff, shEff, funct};
        end else if (isJ) begin
            word = {opcode, target};
        end else begin
            word = {opcode, rsEff, rtEff, imm};
        end
    end

endmodule

// File: rtl/mips_inst_encoder.sv
// Program-load encoder: writes encoded MIPS words to imem from address 0, holding the CPU in reset.
// Define MIPS_INST_ENC_CHECK_EN to abort on nonzero unused fields instead of silently zeroing them.
module mips_inst_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    encState_e         state;
    logic [ADDR_W-1:0] addr;
    logic              wroteTop;
    logic [31:0]       encWord;
    logic              encIllegal;
    logic              encFieldViol;
    logic              badItem;
    logic              overflow;
    logic              accept;

    mips_inst_enc_core u_core (
        .mnem      (in_mnem),
        .rs        (in_rs),
        .rt        (in_rt),
        .rd        (in_rd),
        .shamt     (in_shamt),
        .imm       (in_imm),
        .target    (in_target),
        .word      (encWord),
        .illegal   (encIllegal),
        .fieldViol (encFieldViol)
    );

`ifdef MIPS_INST_ENC_CHECK_EN
    assign badItem = encIllegal | encFieldViol;
`else
    logic unusedFieldViol;
    assign unusedFieldViol = encFieldViol;
    assign badItem         = encIllegal;
`endif

    assign accept = in_valid & in_ready;
    // The top address stays put after its write, so wroteTop tells a second hit from the first.
    assign overflow = (addr == ADDR_MAX) && wroteTop && !in_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            wroteTop  <= 1'b0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        addr      <= '0;
                        wroteTop  <= 1'b0;
                        in_ready  <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_rst_n <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (badItem || overflow) begin
                            state    <= ST_ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= encWord;
                            if (addr == ADDR_MAX) begin
                                wroteTop <= 1'b1;
                            end else begin
                                addr <= addr + ADDR_ONE;
                            end
                            if (in_last) begin
                                state    <= ST_FLUSH;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    state     <= ST_DONE;
                    done      <= 1'b1;
                    cpu_rst_n <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Directed bench for mips_inst_encoder: default-width instance plus an ADDR_W=2 instance for overflow.
module tb_mips_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic        in_valid;
    logic [5:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    logic        in_ready2;
    logic        mem_we2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic        done2;
    logic        err2;
    logic        cpu_rst_n2;

    int nAsserts = 0;
    int nFail    = 0;

    always #5 clk = ~clk;

    mips_inst_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
    );

    mips_inst_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .done(done2), .err(err2), .cpu_rst_n(cpu_rst_n2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic last);
        in_valid  = 1'b1;
        in_mnem   = mn;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
    endtask

    task automatic idleInputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Present one item on the default instance, let it be accepted, check the write that follows.
    task automatic step(input string tag, input logic [5:0] mn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                        input logic [7:0] eAddr, input logic [31:0] eWord);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        drive(mn, rs, rt, rd, sh, imm, tgt, last);
        tick();
        idleInputs();
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(eAddr));
        chk({tag, "_word"}, mem_wdata, eWord);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        idleInputs();
        drive(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();

        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cpurst", 32'(cpu_rst_n), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Single ADDI, last
        pulseStart();
        step("addi", 6'd22, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'd0, 1'b1, 8'd0, 32'h2008_0005);
        chk("addi_ready_low", 32'(in_ready), 32'd0);
        chk("addi_done_early", 32'(done), 32'd0);
        chk("addi_cpurst_early", 32'(cpu_rst_n), 32'd0);
        tick();
        chk("addi_done", 32'(done), 32'd1);
        chk("addi_cpurst", 32'(cpu_rst_n), 32'd1);
        chk("addi_no_extra_we", 32'(mem_we), 32'd0);

        // Restart from DONE, then a back-to-back program; start mid-load must be ignored
        pulseStart();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_cpurst", 32'(cpu_rst_n), 32'd0);
        step("b2b_add", 6'd1, 5'd8, 5'd9, 5'd10, 5'd0, 16'd0, 26'd0, 1'b0, 8'd0, 32'h0109_5020);
        step("b2b_sll", 6'd11, 5'd0, 5'd9, 5'd8, 5'd2, 16'd0, 26'd0, 1'b0, 8'd1, 32'h0009_4080);
        step("b2b_lw", 6'd18, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b0, 8'd2, 32'h8FA8_0004);
        start = 1'b1;
        step("b2b_beq", 6'd20, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b0, 8'd3, 32'h1109_FFFF);
        start = 1'b0;
        step("b2b_lui", 6'd29, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0, 8'd4, 32'h3C08_1234);
        step("b2b_j", 6'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0010, 1'b1, 8'd5, 32'h0800_0010);
        tick();
        chk("b2b_done", 32'(done), 32'd1);

        // Illegal mnemonic at position 2
        pulseStart();
        step("ill_or", 6'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0, 8'd0, 32'h0022_1825);
        step("ill_jal", 6'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FF_FFFF, 1'b0, 8'd1, 32'h0FFF_FFFF);
        drive(6'd40, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        tick();
        idleInputs();
        chk("ill_no_we", 32'(mem_we), 32'd0);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_cpurst", 32'(cpu_rst_n), 32'd0);
        chk("ill_ready", 32'(in_ready), 32'd0);
        tick();
        chk("ill_still_no_we", 32'(mem_we), 32'd0);
        chk("ill_err_hold", 32'(err), 32'd1);
        pulseStart();
        chk("reload_err_clr", 32'(err), 32'd0);
        step("reload_sub", 6'd3, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0, 1'b1, 8'd0, 32'h0085_3022);
        tick();
        chk("reload_done", 32'(done), 32'd1);

        // SLL with nonzero rs
        pulseStart();
        drive(6'd11, 5'd3, 5'd9, 5'd8, 5'd2, 16'd0, 26'd0, 1'b1);
        tick();
        idleInputs();
`ifdef MIPS_INST_ENC_CHECK_EN
        chk("sllrs_no_we", 32'(mem_we), 32'd0);
        chk("sllrs_err", 32'(err), 32'd1);
`else
        chk("sllrs_we", 32'(mem_we), 32'd1);
        chk("sllrs_word", mem_wdata, 32'h0009_4080);
        chk("sllrs_err", 32'(err), 32'd0);
        tick();
        chk("sllrs_done", 32'(done), 32'd1);
`endif

        // Overflow on the ADDR_W=2 instance; default instance is idle-ready-low here
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("ovf_ready", 32'(in_ready2), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(6'd22, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i), 26'd0, 1'b0);
            tick();
            idleInputs();
            chk($sformatf("ovf_we%0d", i), 32'(mem_we2), 32'd1);
            chk($sformatf("ovf_addr%0d", i), 32'(mem_addr2), 32'(i));
            chk($sformatf("ovf_word%0d", i), mem_wdata2, 32'h2000_0000 | (32'(i) << 16) | 32'(i));
        end
        drive(6'd22, 5'd0, 5'd4, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0);
        tick();
        idleInputs();
        chk("ovf_no_we", 32'(mem_we2), 32'd0);
        chk("ovf_err", 32'(err2), 32'd1);
        chk("ovf_addr_hold", 32'(mem_addr2), 32'd3);
        chk("ovf_main_untouched", 32'(mem_we), 32'd0);

        // Reset asserted while a write is in flight and another item is being accepted
        pulseStart();
        step("rst_mid_add", 6'd1, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0, 1'b0, 8'd0, 32'h0021_0820);
        drive(6'd2, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0, 1'b0);
        rst_n = 1'b0;
        tick();
        idleInputs();
        chk("rstmid_we", 32'(mem_we), 32'd0);
        chk("rstmid_ready", 32'(in_ready), 32'd0);
        chk("rstmid_addr", 32'(mem_addr), 32'd0);
        chk("rstmid_wdata", mem_wdata, 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_err", 32'(err), 32'd0);
        chk("rstmid_cpurst", 32'(cpu_rst_n), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rstmid_idle_ready", 32'(in_ready), 32'd0);
        chk("rstmid_idle_we", 32'(mem_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
